// File: rtl/ipm2l_sync_fifo_v2_0.sv
// Single-clock FIFO with level-derived status flags, sticky error flags, and a
// selectable registered-read or first-word-fall-through read port.
module ipm2l_sync_fifo_v2_0 #(
  parameter int c_DATA_WIDTH       = 32,
  parameter int c_DEPTH_WIDTH      = 9,
  parameter int c_FWFT_EN          = 0,
  parameter int c_ALMOST_FULL_NUM  = 508,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  output logic                     rd_valid,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [c_DEPTH_WIDTH:0]   water_level,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << c_DEPTH_WIDTH;
  localparam logic [c_DEPTH_WIDTH:0] LVL_ONE  = (c_DEPTH_WIDTH + 1)'(1);
  localparam logic [c_DEPTH_WIDTH:0] LVL_FULL = (c_DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [c_DEPTH_WIDTH:0] LVL_AF   = (c_DEPTH_WIDTH + 1)'(c_ALMOST_FULL_NUM);
  localparam logic [c_DEPTH_WIDTH:0] LVL_AE   = (c_DEPTH_WIDTH + 1)'(c_ALMOST_EMPTY_NUM);

  generate
    if (c_DATA_WIDTH < 1 || c_DATA_WIDTH > 256 ||
        c_DEPTH_WIDTH < 2 || c_DEPTH_WIDTH > 12 ||
        (c_FWFT_EN != 0 && c_FWFT_EN != 1) ||
        c_ALMOST_FULL_NUM < 1 || c_ALMOST_FULL_NUM > DEPTH ||
        c_ALMOST_EMPTY_NUM < 0 || c_ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_param
      $error("ipm2l_sync_fifo_v2_0: parameter out of range");
    end
  endgenerate

  logic [c_DATA_WIDTH-1:0]  mem [DEPTH];
  logic [c_DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [c_DEPTH_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [c_DEPTH_WIDTH:0]   level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     wr_acc, rd_acc;

  // Flags come only from the registered level, never from the request inputs.
  assign wr_full      = (level_q == LVL_FULL);
  assign rd_empty     = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign water_level  = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~wr_full;
  assign rd_acc = rd_en & ~rd_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + LVL_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + LVL_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // A new error in the same cycle as err_clr must survive the clear.
    overflow_d  = (overflow_q & ~err_clr) | (wr_en & wr_full);
    underflow_d = (underflow_q & ~err_clr) | (rd_en & rd_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[c_DEPTH_WIDTH-1:0]] <= wr_data;
  end

  generate
    if (c_FWFT_EN != 0) begin : g_fwft
      // Head word is always visible; a write into an empty FIFO shows up as
      // soon as the level register leaves zero.
      assign rd_data  = mem[rd_ptr_q[c_DEPTH_WIDTH-1:0]];
      assign rd_valid = ~rd_empty;
    end else begin : g_std
      logic [c_DATA_WIDTH-1:0] rd_data_q;
      logic                    rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr_q[c_DEPTH_WIDTH-1:0]];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_ipm2l_sync_fifo_v2_0.sv
// Scoreboard bench: standard-mode and FWFT-mode FIFO instances driven from
// directed sequences, expected words queued on write and compared on read.
module tb_ipm2l_sync_fifo_v2_0;

  localparam int DW = 32;
  localparam int D  = 512;

  logic          clk = 1'b0;
  logic          rst_n;

  logic [DW-1:0] wr_data, rd_data;
  logic          wr_en, rd_en, err_clr;
  logic          wr_full, almost_full, rd_valid, rd_empty, almost_empty;
  logic          overflow, underflow;
  logic [9:0]    water_level;

  logic [DW-1:0] f_wr_data, f_rd_data;
  logic          f_wr_en, f_rd_en, f_err_clr;
  logic          f_wr_full, f_almost_full, f_rd_valid, f_rd_empty, f_almost_empty;
  logic          f_overflow, f_underflow;
  logic [9:0]    f_water_level;

  int            vectors     = 0;
  int            miscompares = 0;

  int            level_m;
  bit            ovf_m, udf_m;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fexp_q[$];

  always #5 clk = ~clk;

  ipm2l_sync_fifo_v2_0 u_std (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .almost_empty(almost_empty), .water_level(water_level),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  ipm2l_sync_fifo_v2_0 #(.c_FWFT_EN(1)) u_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_full(f_wr_full), .almost_full(f_almost_full),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
    .almost_empty(f_almost_empty), .water_level(f_water_level),
    .err_clr(f_err_clr), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of standard-instance stimulus; model predicts accept/flags.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr);
    bit            wa, ra;
    logic [DW-1:0] exp_d;
    wa = we && (level_m < D);
    ra = re && (level_m > 0);
    ovf_m = (ovf_m && !clr) || (we && level_m == D);
    udf_m = (udf_m && !clr) || (re && level_m == 0);
    wr_en = we; wr_data = wd; rd_en = re; err_clr = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    if (ra) begin
      exp_d = exp_q.pop_front();
      check_eq("rd_data", 64'(rd_data), 64'(exp_d));
    end
    if (wa) exp_q.push_back(wd);
    level_m = level_m + int'(wa) - int'(ra);
    check_eq("rd_valid", 64'(rd_valid), 64'(ra));
    check_eq("water_level", 64'(water_level), 64'(level_m));
    check_eq("wr_full", 64'(wr_full), 64'(level_m == D));
    check_eq("rd_empty", 64'(rd_empty), 64'(level_m == 0));
    check_eq("almost_full", 64'(almost_full), 64'(level_m >= 508));
    check_eq("almost_empty", 64'(almost_empty), 64'(level_m <= 4));
    check_eq("overflow", 64'(overflow), 64'(ovf_m));
    check_eq("underflow", 64'(underflow), 64'(udf_m));
    $display("txn we=%0b wd=%h re=%0b clr=%0b lvl=%0d rd_valid=%0b rd_data=%h",
             we, wd, re, clr, water_level, rd_valid, rd_data);
  endtask

  task automatic model_reset();
    exp_q.delete();
    fexp_q.delete();
    level_m = 0;
    ovf_m   = 1'b0;
    udf_m   = 1'b0;
  endtask

  task automatic check_reset_state();
    check_eq("rst_level", 64'(water_level), 64'd0);
    check_eq("rst_empty", 64'(rd_empty), 64'd1);
    check_eq("rst_aempty", 64'(almost_empty), 64'd1);
    check_eq("rst_full", 64'(wr_full), 64'd0);
    check_eq("rst_afull", 64'(almost_full), 64'd0);
    check_eq("rst_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    check_eq("rst_udf", 64'(underflow), 64'd0);
    check_eq("rst_f_empty", 64'(f_rd_empty), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] fexp;
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_wr_data = '0;
    model_reset();
    #1;
    check_reset_state();
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write three, read three
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Underflow, then simultaneous write+read on empty
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h44, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, overflow attempt, clear, read+write on full
    for (int i = 0; i < D; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b1, 32'hFEED_F00D, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Sustained read+write on full across many pointer wraps
    for (int i = 0; i < 2000; i++) step(1'b1, 32'h1000_0000 + i, 1'b1, 1'b0);

    // Drain a few to cross the almost_full boundary downward
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A_0002, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // FWFT instance: data falls through without rd_en
    f_wr_en = 1'b1; f_wr_data = 32'hA5; fexp_q.push_back(32'hA5);
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    check_eq("f_empty_after_wr", 64'(f_rd_empty), 64'd0);
    check_eq("f_valid_after_wr", 64'(f_rd_valid), 64'd1);
    check_eq("f_rd_data_head", 64'(f_rd_data), 64'(fexp_q[0]));
    $display("txn fwft wr=a5 rd_empty=%0b rd_data=%h", f_rd_empty, f_rd_data);
    @(posedge clk); #1;
    check_eq("f_rd_data_hold", 64'(f_rd_data), 64'(fexp_q[0]));
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    fexp = fexp_q.pop_front();
    check_eq("f_empty_after_pop", 64'(f_rd_empty), 64'd1);
    check_eq("f_valid_after_pop", 64'(f_rd_valid), 64'd0);
    check_eq("f_level_after_pop", 64'(f_water_level), 64'd0);
    $display("txn fwft pop %h rd_empty=%0b", fexp, f_rd_empty);

    f_wr_en = 1'b1; f_wr_data = 32'hB1; fexp_q.push_back(32'hB1);
    @(posedge clk); #1;
    f_wr_data = 32'hB2; fexp_q.push_back(32'hB2);
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    check_eq("f_level_two", 64'(f_water_level), 64'd2);
    check_eq("f_rd_data_b1", 64'(f_rd_data), 64'(fexp_q[0]));
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    fexp = fexp_q.pop_front();
    check_eq("f_rd_data_b2", 64'(f_rd_data), 64'(fexp_q[0]));
    check_eq("f_valid_b2", 64'(f_rd_valid), 64'd1);
    $display("txn fwft pop %h next=%h", fexp, f_rd_data);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
